usr_param: RTL and testbench

- Parametrised universal shift register, successor to the fixed 4-bit shift/load register.
- Adds generic width, serial inputs, rotate and arithmetic-shift modes, a clock enable, and a multi-cycle burst shift with busy/done handshake.
- Used in serial/parallel conversion and bit-alignment paths of the NRSC data chain.

---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_step_logic.sv | 28 ++
 rtl/usr_param.sv | 113 +++++++++++
 tb/tb_usr_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Modes that can be repeated as a multi-step burst.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step_logic.sv
// Combinational next-register computation for one shift/rotate/load step.
module usr_step_logic
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next
);

  // Select the next register value for the requested operation.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
      MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
      MODE_LOAD: q_next = d;
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with clock enable and burst shifting.
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  state_e           state, state_n;
  logic [WIDTH-1:0] q_r, q_n, step_q;
  logic [CNT_W-1:0] rem, rem_n;
  logic [2:0]       lmode, lmode_n, step_mode;
  logic             lser, lser_n, step_ser;
  logic             done_r, done_n;

  usr_step_logic #(.WIDTH(WIDTH)) u_step (
    .q      (q_r),
    .d      (d),
    .mode   (step_mode),
    .ser_in (step_ser),
    .q_next (step_q)
  );

  // Register update; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      rem    <= '0;
      lmode  <= MODE_HOLD;
      lser   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      rem    <= rem_n;
      lmode  <= lmode_n;
      lser   <= lser_n;
      done_r <= done_n;
    end
  end

  // Next-state logic: a burst replays its latched mode while inputs are ignored.
  always_comb begin
    state_n   = state;
    q_n       = q_r;
    rem_n     = rem;
    lmode_n   = lmode;
    lser_n    = lser;
    done_n    = 1'b0;
    step_mode = mode;
    step_ser  = ser_in;

    if (state == BUSY) begin
      step_mode = lmode;
      step_ser  = lser;
    end else if (start && (cnt == '0)) begin
      step_mode = MODE_HOLD;
    end

    if (en) begin
      case (state)
        IDLE: begin
          q_n = step_q;
          if (start) begin
            if (is_shift_mode(mode) && (cnt != '0)) begin
              lmode_n = mode;
              lser_n  = ser_in;
              rem_n   = cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) begin
                done_n = 1'b1;
              end else begin
                state_n = BUSY;
              end
            end else begin
              done_n = 1'b1;
            end
          end
        end
        BUSY: begin
          q_n   = step_q;
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign q      = q_r;
  assign so_msb = q_r[WIDTH-1];
  assign so_lsb = q_r[0];
  assign busy   = (state == BUSY);
  assign done   = done_r;

endmodule

// File: tb/tb_usr_param.sv
// Scoreboard testbench for usr_param (WIDTH=4) against an arithmetic reference model.
module tb_usr_param;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             ser_in;
  logic [WIDTH-1:0] d;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             so_msb;
  logic             so_lsb;
  logic             busy;
  logic             done;

  typedef struct {
    int q;
    bit busy;
    bit done;
    int id;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model state, kept as plain integers.
  int m_q = 0;
  bit m_busy = 0;
  bit m_done = 0;
  int m_left = 0;
  int m_mode = 0;
  int m_ser = 0;

  usr_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .ser_in (ser_in),
    .d      (d),
    .start  (start),
    .cnt    (cnt),
    .q      (q),
    .so_msb (so_msb),
    .so_lsb (so_lsb),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One operation on a 4-bit value using arithmetic on integers.
  function automatic int model_op(int m, int qv, int s, int dv);
    case (m)
      1: return (qv * 2 + s) % 16;
      2: return qv / 2 + s * 8;
      3: return dv;
      4: return (qv * 2) % 16 + qv / 8;
      5: return qv / 2 + (qv % 2) * 8;
      6: return qv / 2 + (qv / 8) * 8;
      default: return qv;
    endcase
  endfunction

  function automatic bit model_is_burst(int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  // Drive one cycle of inputs, advance the model, and queue the expected outcome.
  task automatic applyStimulus(input bit r, input bit e, input int m, input int s,
                               input int dv, input bit st, input int c);
    exp_t x;
    @(negedge clk);
    rst    = r;
    en     = e;
    mode   = 3'(m);
    ser_in = s[0];
    d      = 4'(dv);
    start  = st;
    cnt    = 4'(c);

    if (r) begin
      m_q = 0; m_busy = 0; m_done = 0; m_left = 0;
    end else if (!e) begin
      m_done = 0;
    end else if (m_busy) begin
      m_q = model_op(m_mode, m_q, m_ser, dv);
      m_left = m_left - 1;
      m_busy = (m_left > 0);
      m_done = (m_left == 0);
    end else if (st) begin
      if (model_is_burst(m) && c > 0) begin
        m_q = model_op(m, m_q, s, dv);
        m_mode = m;
        m_ser = s;
        m_left = c - 1;
        m_busy = (m_left > 0);
        m_done = (m_left == 0);
      end else begin
        if (c > 0) m_q = model_op(m, m_q, s, dv);
        m_done = 1;
      end
    end else begin
      m_q = model_op(m, m_q, s, dv);
      m_done = 0;
    end

    x.q = m_q; x.busy = m_busy; x.done = m_done; x.id = step_id;
    step_id++;
    expq.push_back(x);
  endtask

  // Pop the oldest expectation and compare it with what the DUT presents.
  task automatic checkOutput();
    exp_t x;
    logic [7:0] got, want;
    int qv;
    x = expq.pop_front();
    qv = x.q;
    got  = {q, so_msb, so_lsb, busy, done};
    want = {4'(qv), 1'(qv / 8), 1'(qv % 2), x.busy, x.done};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL step%0d {q,msb,lsb,busy,done}: got %b required %b", x.id, got, want);
    end
  endtask

  // Monitor: compare after each edge once an expectation is queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput();
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; ser_in = 1'b0; d = '0; start = 1'b0; cnt = '0;

    // Reset and load
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(1, 1, 3, 0, 11, 0, 0);
    // Shifts, reserved mode and enable low
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(0, 1, 2, 1, 0, 0, 0);
    applyStimulus(0, 1, 7, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    // Rotate and arithmetic shift
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 11, 0, 0);
    applyStimulus(0, 1, 6, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 6, 0, 0);
    applyStimulus(0, 1, 6, 0, 0, 0, 0);
    // Burst ROL x3 with LOAD requested mid-burst
    applyStimulus(0, 1, 3, 0, 1, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 1, 3);
    applyStimulus(0, 1, 3, 0, 5, 1, 7);
    applyStimulus(0, 1, 3, 0, 5, 1, 7);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    // Stalled burst
    applyStimulus(0, 1, 3, 0, 1, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 1, 3);
    applyStimulus(0, 0, 3, 0, 9, 1, 2);
    applyStimulus(0, 0, 3, 0, 9, 1, 2);
    applyStimulus(0, 1, 3, 0, 9, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    // Aborted burst
    applyStimulus(0, 1, 3, 0, 1, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 1, 3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    // Degenerate bursts
    applyStimulus(0, 1, 3, 0, 9, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 5, 1, 5);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 1, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 25),
                    int'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
